// File: rtl/error_diffusion_sequencer.sv
// error_diffusion_sequencer: line/frame sequencer feeding an error diffusion kernel from an error line buffer
module error_diffusion_sequencer #(
  parameter int INPUT_BITS  = 8,
  parameter int OUTPUT_BITS = 4,
  parameter int ERROR_BITS  = 9,
  parameter int ADDR_BITS   = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_BITS-1:0]   line_width,
  input  logic                   frame_start,
  input  logic [INPUT_BITS-1:0]  s_pixel,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [OUTPUT_BITS-1:0] m_pixel,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [INPUT_BITS-1:0]  k_pixel_in,
  output logic [ERROR_BITS-1:0]  k_err_line_buffer_in,
  output logic [ERROR_BITS-1:0]  k_err_left_in,
  output logic [ERROR_BITS-1:0]  k_err_bottom_left_in,
  output logic [ERROR_BITS-1:0]  k_err_bottom_in,
  input  logic [OUTPUT_BITS-1:0] k_pixel_out,
  input  logic [ERROR_BITS-1:0]  k_err_right_out,
  input  logic [ERROR_BITS-1:0]  k_err_bottom_left_out,
  input  logic [ERROR_BITS-1:0]  k_err_bottom_out,
  input  logic [ERROR_BITS-1:0]  k_err_bottom_right_out,
  output logic                   lb_rd_en,
  output logic [ADDR_BITS-1:0]   lb_rd_addr,
  input  logic [ERROR_BITS-1:0]  lb_rd_data,
  output logic                   lb_wr_en,
  output logic [ADDR_BITS-1:0]   lb_wr_addr,
  output logic [ERROR_BITS-1:0]  lb_wr_data,
  output logic                   busy
);
  typedef enum logic [2:0] {IDLE, CLEAR, PREFETCH, RUN, FLUSH} state_t;
  state_t state;
  logic [ADDR_BITS-1:0] x, w;
  logic [ERROR_BITS-1:0] r_left, r_bl, r_b;
  logic last, accept;
  assign last = x == w - ADDR_BITS'(1);
  assign s_ready = state == RUN && (!m_valid || m_ready);
  assign accept = s_valid && s_ready;
  assign busy = state == CLEAR || state == PREFETCH || state == FLUSH;
  assign k_pixel_in = s_pixel;
  assign k_err_line_buffer_in = lb_rd_data;
  assign k_err_left_in = r_left;
  assign k_err_bottom_left_in = r_bl;
  assign k_err_bottom_in = r_b;
  assign lb_rd_en = state == PREFETCH || (accept && !last);
  assign lb_rd_addr = state == PREFETCH ? '0 : x + ADDR_BITS'(1);
  assign lb_wr_en = state == CLEAR || state == FLUSH || (accept && x != '0);
  assign lb_wr_addr = state == CLEAR ? x : state == FLUSH ? w - ADDR_BITS'(1) : x - ADDR_BITS'(1);
  assign lb_wr_data = state == CLEAR ? '0 : state == FLUSH ? r_bl : k_err_bottom_left_out;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      x       <= '0;
      w       <= '0;
      r_left  <= '0;
      r_bl    <= '0;
      r_b     <= '0;
      m_pixel <= '0;
      m_valid <= 1'b0;
    end else begin
      m_valid <= accept || (m_valid && !m_ready);
      if (accept) m_pixel <= k_pixel_out;
      if (frame_start) begin
        state <= CLEAR;
        x     <= '0;
        w     <= line_width;
      end else case (state)
        CLEAR: begin
          x     <= last ? '0 : x + ADDR_BITS'(1);
          state <= last ? PREFETCH : CLEAR;
        end
        PREFETCH: begin
          r_left <= '0;
          r_bl   <= '0;
          r_b    <= '0;
          state  <= RUN;
        end
        RUN: if (accept) begin
          r_left <= k_err_right_out;
          r_bl   <= k_err_bottom_out;
          r_b    <= k_err_bottom_right_out;
          x      <= last ? '0 : x + ADDR_BITS'(1);
          state  <= last ? FLUSH : RUN;
        end
        FLUSH: state <= PREFETCH;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_error_diffusion_sequencer.sv
// tb_error_diffusion_sequencer: randomized check of the sequencer against a line-based Floyd-Steinberg model
module tb_error_diffusion_sequencer;
  logic clk = 1'b0;
  logic rst_n, frame_start, s_valid, s_ready, m_valid, m_ready;
  logic [10:0] line_width, lb_rd_addr, lb_wr_addr;
  logic [7:0] s_pixel, k_pixel_in;
  logic m_pixel, k_pixel_out;
  logic [8:0] k_err_line_buffer_in, k_err_left_in, k_err_bottom_left_in, k_err_bottom_in;
  logic [8:0] k_err_right_out, k_err_bottom_left_out, k_err_bottom_out, k_err_bottom_right_out;
  logic lb_rd_en, lb_wr_en, busy;
  logic [8:0] lb_rd_data, lb_wr_data;
  logic [8:0] mem [0:2047];
  int tests = 0, fails = 0;
  int expq [$];
  int cur [0:2047];
  int nxt [0:2047];
  int pix [0:2047];
  int ex [0:2047];
  int k_s, k_e, wt;
  always #5 clk = ~clk;
  error_diffusion_sequencer #(.OUTPUT_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .line_width(line_width), .frame_start(frame_start),
    .s_pixel(s_pixel), .s_valid(s_valid), .s_ready(s_ready),
    .m_pixel(m_pixel), .m_valid(m_valid), .m_ready(m_ready),
    .k_pixel_in(k_pixel_in), .k_err_line_buffer_in(k_err_line_buffer_in), .k_err_left_in(k_err_left_in),
    .k_err_bottom_left_in(k_err_bottom_left_in), .k_err_bottom_in(k_err_bottom_in),
    .k_pixel_out(k_pixel_out), .k_err_right_out(k_err_right_out), .k_err_bottom_left_out(k_err_bottom_left_out),
    .k_err_bottom_out(k_err_bottom_out), .k_err_bottom_right_out(k_err_bottom_right_out),
    .lb_rd_en(lb_rd_en), .lb_rd_addr(lb_rd_addr), .lb_rd_data(lb_rd_data),
    .lb_wr_en(lb_wr_en), .lb_wr_addr(lb_wr_addr), .lb_wr_data(lb_wr_data), .busy(busy)
  );
  always_comb begin
    k_s = int'(k_pixel_in) + int'($signed(k_err_line_buffer_in)) + int'($signed(k_err_left_in));
    k_e = k_s - (k_s >= 128 ? 255 : 0);
    k_pixel_out = k_s >= 128;
    k_err_right_out = 9'((k_e * 7) >>> 4);
    k_err_bottom_left_out = 9'(int'($signed(k_err_bottom_left_in)) + ((k_e * 3) >>> 4));
    k_err_bottom_out = 9'(int'($signed(k_err_bottom_in)) + ((k_e * 5) >>> 4));
    k_err_bottom_right_out = 9'(k_e >>> 4);
  end
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 9'($urandom);
    lb_rd_data = 9'h0a5;
  end
  always @(posedge clk) begin
    if (lb_wr_en) mem[lb_wr_addr] <= lb_wr_data;
    if (lb_rd_en) lb_rd_data <= mem[lb_rd_addr];
  end
  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask
  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
  endtask
  always @(negedge clk)
    if (rst_n && m_valid && m_ready) begin
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL m_pixel_extra: got output %0d, required no output", m_pixel);
      end else chk("m_pixel", int'(m_pixel), expq.pop_front());
    end
  initial begin
    #2000000;
    tests++;
    fails++;
    $display("FAIL watchdog: simulation still running, required completion");
    summary();
    $finish;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic void model_clear();
    for (int i = 0; i < 2048; i++) cur[i] = 0;
  endfunction
  function automatic void model_line(input int w);
    int carry, s, e;
    carry = 0;
    for (int i = 0; i < w; i++) nxt[i] = 0;
    for (int i = 0; i < w; i++) begin
      s = pix[i] + cur[i] + carry;
      ex[i] = s >= 128 ? 1 : 0;
      e = s - (s >= 128 ? 255 : 0);
      carry = (e * 7) >>> 4;
      if (i > 0) nxt[i-1] += (e * 3) >>> 4;
      nxt[i] += (e * 5) >>> 4;
      if (i < w - 1) nxt[i+1] += e >>> 4;
    end
    for (int i = 0; i < w; i++) cur[i] = nxt[i];
  endfunction
  task automatic send_pixel(input int p, input int e, input int idle_max, input bit rnd, output int waited);
    waited = 0;
    repeat ($urandom_range(idle_max, 0)) begin
      s_valid = 1'b0;
      if (rnd) m_ready = $urandom_range(3, 0) != 0;
      tick();
    end
    s_pixel = 8'(p);
    s_valid = 1'b1;
    forever begin
      if (rnd) m_ready = $urandom_range(3, 0) != 0;
      @(negedge clk);
      if (s_ready) break;
      waited++;
      if (waited > 100) begin
        tests++;
        fails++;
        $display("FAIL s_ready_timeout: waited %0d cycles, required ready within 100", waited);
        summary();
        $finish;
      end
      tick();
    end
    expq.push_back(e);
    tick();
    s_valid = 1'b0;
  endtask
  task automatic send_line(input int w, input int n, input int c, input int idle_max, input bit rnd, output int first_wait);
    int t;
    for (int i = 0; i < w; i++) pix[i] = c < 0 ? int'($urandom_range(255, 0)) : c;
    model_line(w);
    first_wait = 0;
    for (int i = 0; i < n; i++) begin
      send_pixel(pix[i], ex[i], idle_max, rnd, t);
      if (i == 0) first_wait = t;
    end
  endtask
  task automatic start_frame(input int w);
    s_valid = 1'b0;
    frame_start = 1'b1;
    line_width = 11'(w);
    tick();
    frame_start = 1'b0;
    model_clear();
  endtask
  initial begin
    rst_n = 1'b0;
    frame_start = 1'b0;
    line_width = '0;
    s_pixel = '0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    model_clear();
    repeat (3) tick();
    @(negedge clk);
    chk("reset_outs", {s_ready, m_valid, lb_rd_en, lb_wr_en, busy, m_pixel}, 0);
    tick();
    rst_n = 1'b1;
    s_valid = 1'b1;
    tick();
    @(negedge clk);
    chk("idle_not_ready", {s_ready, busy}, 0);
    tick();
    start_frame(4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("clear_ctrl", {lb_wr_en, lb_rd_en, busy}, 3'b101);
      chk("clear_addr", lb_wr_addr, i);
      chk("clear_data", lb_wr_data, 0);
      tick();
    end
    @(negedge clk);
    chk("prefetch_ctrl", {lb_rd_en, lb_wr_en, busy, s_ready}, 4'b1010);
    chk("prefetch_addr", lb_rd_addr, 0);
    tick();
    @(negedge clk);
    chk("run_ready", {s_ready, busy}, 2'b10);
    tick();
    send_line(4, 4, 128, 0, 0, wt);
    chk("model_line0", ex[0] * 8 + ex[1] * 4 + ex[2] * 2 + ex[3], 10);
    chk("model_lb0", cur[0], -27);
    chk("model_lb3", cur[3], 20);
    send_line(4, 4, 128, 0, 0, wt);
    chk("line_gap", wt, 2);
    chk("model_line1", ex[0] * 8 + ex[1] * 4 + ex[2] * 2 + ex[3], 5);
    start_frame(8);
    send_line(8, 3, -1, 0, 0, wt);
    m_ready = 1'b0;
    s_pixel = 8'(pix[3]);
    s_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_quiet", {s_ready, lb_rd_en, lb_wr_en, m_valid}, 4'b0001);
      chk("stall_hold", int'(m_pixel), ex[2]);
      tick();
    end
    m_ready = 1'b1;
    for (int i = 3; i < 8; i++) send_pixel(pix[i], ex[i], 0, 0, wt);
    send_line(8, 8, -1, 1, 1, wt);
    m_ready = 1'b1;
    send_line(8, 2, -1, 0, 0, wt);
    m_ready = 1'b0;
    frame_start = 1'b1;
    line_width = 11'd6;
    @(negedge clk);
    chk("fs_pending", m_valid, 1);
    tick();
    frame_start = 1'b0;
    model_clear();
    @(negedge clk);
    chk("fs_clear_ctrl", {lb_wr_en, busy, m_valid}, 3'b111);
    chk("fs_clear_addr", lb_wr_addr, 0);
    chk("fs_held_pixel", int'(m_pixel), ex[1]);
    tick();
    m_ready = 1'b1;
    send_line(6, 6, -1, 1, 1, wt);
    send_line(6, 6, -1, 1, 1, wt);
    m_ready = 1'b1;
    start_frame(1);
    send_line(1, 1, 200, 0, 0, wt);
    @(negedge clk);
    chk("w1_flush_ctrl", {lb_wr_en, busy}, 2'b11);
    chk("w1_flush_addr", lb_wr_addr, 0);
    chk("w1_flush_data", int'($signed(lb_wr_data)), -18);
    chk("w1_model_pixel", ex[0], 1);
    tick();
    send_line(1, 1, -1, 0, 0, wt);
    for (int f = 0; f < 6; f++) begin
      int w, nl;
      w = $urandom_range(12, 1);
      nl = $urandom_range(3, 1);
      start_frame(w);
      for (int l = 0; l < nl; l++) send_line(w, w, -1, 2, 1, wt);
    end
    m_ready = 1'b1;
    s_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("drain_empty", expq.size(), 0);
    tick();
    start_frame(8);
    send_line(8, 5, -1, 0, 0, wt);
    @(negedge clk);
    chk("x5_rd_addr", lb_rd_addr, 6);
    tick();
    m_ready = 1'b0;
    s_valid = 1'b1;
    rst_n = 1'b0;
    expq.delete();
    @(negedge clk);
    chk("rst_mid", {s_ready, m_valid, lb_rd_en, lb_wr_en, busy, m_pixel}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_idle", {s_ready, busy, m_valid}, 0);
    summary();
    $finish;
  end
endmodule
